caravel: RTL and testbench
==========================

CARAVEL -- requirements
Module: caravel

Interface
REQ-001 CLKS_PER_BIT, default 347, clock cycles per UART bit (40 MHz / 115200 baud).
REQ-002 wb_clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 wb_rst_i  input  1  reset; synchronous and active-high.
REQ-004 io_in  input  38  pad inputs; only io_in[5] (UART RX, idle high) SHALL be used.
REQ-005 io_out  output  38  [23:8] result word, [37] ready; all other bits SHALL drive 0.
REQ-006 io_oeb  output  38  active-low output enable; bits [37] and [23:8] SHALL be 0, all others 1, constant.

Function
REQ-007 The block SHALL contain a UART receiver on io_in[5]: 8N1 format, LSB first.
REQ-008 The RX input SHALL pass through a 2-flop synchronizer before use.
REQ-009 Start detection: a falling edge while idle; the start bit SHALL be re-checked at CLKS_PER_BIT/2 and the frame abandoned if RX is high.
REQ-010 Data bits and stop bit SHALL be sampled at bit centres, CLKS_PER_BIT apart.
REQ-011 Receiver FSM states SHALL be IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
REQ-012 A stop bit sampled 0 is a framing error: the byte SHALL be discarded and the byte counter cleared to 0.
REQ-013 Bytes SHALL be collected in groups of four: A[15:8], A[7:0], B[15:8], B[7:0]; a 2-bit counter SHALL wrap 3 -> 0.
REQ-014 On acceptance of the 4th byte, the block SHALL compute A*B in bfloat16 (1 sign, 8 exponent with bias 127, 7 fraction bits).
REQ-015 The product SHALL appear on io_out[23:8] exactly 1 cycle after the stop-bit sample of the 4th byte.
REQ-016 The result SHALL hold until the next product; a partial group SHALL leave the result unchanged.
REQ-017 Multiply arithmetic:
- sign = sA XOR sB
- 8x8 significand product, exponent eA+eB-127
- normalize by at most 1 bit
- round to nearest, ties to even
REQ-018 Subnormal inputs SHALL be treated as zero; an underflowed result SHALL flush to signed zero.
REQ-019 Exponent overflow, including overflow caused by rounding, SHALL give signed infinity (7F80/FF80).
REQ-020 Special operands:
- Any NaN operand, or inf*0, SHALL give canonical 7FC0.
- inf*finite-nonzero SHALL give signed infinity.
- zero*finite SHALL give signed zero.
REQ-021 io_out[37] (ready) SHALL be 1 from the first cycle after reset deasserts.

Reset
REQ-022 While wb_rst_i=1 at a clock edge:
- io_out[23:8] SHALL be 0000 and io_out[37] SHALL be 0.
- The UART FSM SHALL return to IDLE and the byte counter and operand registers SHALL clear.
REQ-023 Reset mid-frame or mid-group SHALL discard all partial data, with no product output.

Structure
REQ-024 A shared package SHALL hold:
- CLKS_PER_BIT default
- BF16_BIAS=127
- BF16_QNAN=16'h7FC0
- BF16_PINF=16'h7F80
- the UART FSM state enum
REQ-025 The multiplier SHALL be a combinational sub-module bf16_mul (a[15:0], b[15:0] -> p[15:0]); the UART receiver and framing logic SHALL be inline.

Verification
REQ-026 Basic products, each sent as 4 bytes after reset:
- 3F80,4000 -> io_out[23:8]=4000
- 4040,4040 -> 4110
- C000,3F00 -> BF80
REQ-027 Rounding and zero:
- 3F81,3F81 -> 3F82 (round down)
- 0000,4110 -> 0000
- 8000,3F80 -> 8000
REQ-028 Specials:
- 7F00,7F00 -> 7F80
- 7F80,0000 -> 7FC0
- 7FC1,3F80 -> 7FC0
- FF80,4000 -> FF80
REQ-029 Framing error: the 2nd byte is sent with stop bit 0 and 4 good bytes follow -> only the good group produces a result.
REQ-030 Timing: the result SHALL update exactly 1 cycle after the 4th stop-bit sample.
REQ-031 Ready and reset:
- ready=0 during reset and 1 afterwards.
- Reset asserted after 2 bytes, then 4 bytes 3F80,4000 -> 4000.

Source files
------------

// File: rtl/caravel_pkg.sv
// Shared constants and UART receiver state encoding for the caravel bf16 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package caravel_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 347;  // 40 MHz / 115200 baud

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/caravel_bf16_mul.sv
// Combinational bfloat16 multiply, round-to-nearest-even, subnormals treated as zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module bf16_mul
    import caravel_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic              p_sign;
    logic [7:0]        ea, eb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]       prod;
    logic [7:0]        mant;
    logic              guard, sticky, round_up;
    logic [8:0]        mant_r;
    logic signed [9:0] exp_n, exp_r;

    assign p_sign = a[15] ^ b[15];
    assign ea     = a[14:7];
    assign eb     = b[14:7];
    assign a_nan  = (&ea) & (|a[6:0]);
    assign b_nan  = (&eb) & (|b[6:0]);
    assign a_inf  = (&ea) & ~(|a[6:0]);
    assign b_inf  = (&eb) & ~(|b[6:0]);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);

    always_comb begin
        prod = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        // Product of two [1,2) significands lies in [1,4): at most one normalising shift.
        if (prod[15]) begin
            mant   = prod[15:8];
            guard  = prod[7];
            sticky = |prod[6:0];
        end else begin
            mant   = prod[14:7];
            guard  = prod[6];
            sticky = |prod[5:0];
        end
        exp_n    = {2'b00, ea} + {2'b00, eb} - 10'(BF16_BIAS) + {9'd0, prod[15]};
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {8'd0, round_up};
        // A rounding carry leaves mant_r = 256, whose low 7 bits are already zero.
        exp_r    = exp_n + {9'd0, mant_r[8]};

        p = {p_sign, exp_r[7:0], mant_r[6:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            p = BF16_QNAN;
        end else if (a_inf || b_inf) begin
            p = {p_sign, BF16_PINF[14:0]};
        end else if (a_zero || b_zero) begin
            p = {p_sign, 15'd0};
        end else if (exp_r >= 10'sd255) begin
            p = {p_sign, BF16_PINF[14:0]};
        end else if (exp_r <= 10'sd0) begin
            p = {p_sign, 15'd0};
        end
    end

endmodule

// File: rtl/caravel.sv
// UART (8N1) front end collecting A,B bf16 operands in 4-byte groups; outputs A*B on io_out[23:8].
// Latency: product visible 1 cycle after the stop-bit sample of the 4th byte.
// Backpressure: none; the UART line cannot be stalled, bytes are consumed as they arrive.
module caravel
    import caravel_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta, rx_sync, rx_prev;
    uart_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             byte_vld, frame_err;
    logic [1:0]       byte_cnt;
    logic [15:0]      op_a;
    logic [7:0]       b_hi;
    logic [15:0]      result, mul_p;
    logic             ready;
    logic             unused_io;

    assign unused_io = ^{io_in[37:6], io_in[4:0]};

    // Flops reset to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= io_in[5];
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    state_n   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    shift_n   = {rx_sync, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    state_n   = IDLE;
                    byte_vld  = rx_sync;
                    frame_err = !rx_sync;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // B's low byte is taken straight from the shift register so the product lands on the stop sample.
    bf16_mul u_mul (
        .a (op_a),
        .b ({b_hi, shift}),
        .p (mul_p)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            byte_cnt <= 2'd0;
            op_a     <= 16'd0;
            b_hi     <= 8'd0;
            result   <= 16'd0;
            ready    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            ready   <= 1'b1;
            if (frame_err) begin
                byte_cnt <= 2'd0;
            end else if (byte_vld) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    op_a[15:8] <= shift;
                    2'd1:    op_a[7:0]  <= shift;
                    2'd2:    b_hi       <= shift;
                    default: result     <= mul_p;
                endcase
            end
        end
    end

    assign io_out = {ready, 13'd0, result, 8'd0};
    assign io_oeb = {1'b0, {13{1'b1}}, 16'd0, 8'hFF};

endmodule

// File: tb/tb_caravel.sv
// Scoreboard bench for caravel: UART byte stimulus, queued expected products, decoupled monitor.
module tb_caravel;

    localparam int C    = 16;
    localparam int HALF = C / 2;
    localparam int GAP  = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] last_exp = 16'h0000;
    logic [37:0] oeb_exp  = {1'b0, {13{1'b1}}, 16'h0000, 8'hFF};

    caravel #(.CLKS_PER_BIT(C)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: exact product of the significands, scaled into [128,256) and rounded half-even.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, e, q, biased;
        real  v, fr;
        bit   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[15] ^ b[15];
        ea     = int'(a[14:7]);
        eb     = int'(b[14:7]);
        a_nan  = (ea == 255) && (a[6:0] != 0);
        b_nan  = (eb == 255) && (b[6:0] != 0);
        a_inf  = (ea == 255) && (a[6:0] == 0);
        b_inf  = (eb == 255) && (b[6:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return 16'h7FC0;
        if ((a_inf && b_zero) || (a_zero && b_inf)) return 16'h7FC0;
        if (a_inf || b_inf) return {s, 15'h7F80};
        if (a_zero || b_zero) return {s, 15'h0000};
        v = real'((128 + int'(a[6:0])) * (128 + int'(b[6:0])));
        e = ea + eb - 268;
        while (v >= 256.0) begin
            v = v / 2.0;
            e++;
        end
        q  = int'($floor(v));
        fr = v - $floor(v);
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
        if (q == 256) begin
            q = 128;
            e++;
        end
        biased = e + 134;
        if (biased >= 255) return {s, 15'h7F80};
        if (biased <= 0) return {s, 15'h0000};
        return {s, biased[7:0], q[6:0]};
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 3) != 0) r[14:7] = 8'(100 + $urandom_range(0, 54));
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        io_in[37:6] = $urandom;
        io_in[4:0]  = 5'($urandom);
        io_in[5]    = 1'b0;
        repeat (C) @(negedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            io_in[5] = d[i];
            repeat (C) @(negedge clk);
            #1;
        end
        io_in[5] = stop_bit;
        repeat (C) @(negedge clk);
        #1;
        io_in[5] = 1'b1;
        repeat (GAP) @(negedge clk);
        #1;
    endtask

    // The 4th byte's start bit is first clocked in at posedge cyc+1; two synchroniser stages and
    // the edge detector add 2, the stop-bit centre is HALF + 9*C later, visible one cycle on.
    task automatic send_group(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        int t0;
        exp_q.push_back(exp);
        last_exp = exp;
        send_byte(a[15:8], 1'b1);
        send_byte(a[7:0], 1'b1);
        send_byte(b[15:8], 1'b1);
        t0 = cyc;
        exp_cyc_q.push_back(t0 + 3 + HALF + 9 * C);
        send_byte(b[7:0], 1'b1);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=pending:%0d required=pending:0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        #1;
    endtask

    // Monitor: a change of the result word is the DUT presenting an output.
    initial begin
        logic [15:0] prev;
        logic [15:0] e;
        int          ec;
        prev = 16'h0000;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("oeb", io_oeb, oeb_exp);
            if (rst) begin
                check("rst_result", {22'd0, io_out[23:8]}, 38'd0);
                check("rst_ready", {37'd0, io_out[37]}, 38'd0);
                prev = io_out[23:8];
            end else begin
                check("ready", {37'd0, io_out[37]}, 38'd1);
                check("unused_out", {17'd0, io_out[36:24], io_out[7:0]}, 38'd0);
                if (io_out[23:8] !== prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%h required=no_change", io_out[23:8]);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        check("product", {22'd0, io_out[23:8]}, {22'd0, e});
                        check("latency", 38'(cyc), 38'(ec));
                    end
                    prev = io_out[23:8];
                end
            end
        end
    end

    logic [15:0] dir_a[15] = '{16'h3F80, 16'h4040, 16'hC000, 16'h3F81, 16'h0000,
                               16'h8000, 16'h7F00, 16'h7F80, 16'hFF80, 16'h7FC1,
                               16'h0001, 16'h8080, 16'h7F35, 16'h3FC0, 16'h3FC0};
    logic [15:0] dir_b[15] = '{16'h4000, 16'h4040, 16'h3F00, 16'h3F81, 16'h4110,
                               16'h3F80, 16'h7F00, 16'h0000, 16'h4000, 16'h3F80,
                               16'h3F80, 16'h0080, 16'h3FB5, 16'h3F81, 16'h3F83};
    logic [15:0] dir_p[15] = '{16'h4000, 16'h4110, 16'hBF80, 16'h3F82, 16'h0000,
                               16'h8000, 16'h7F80, 16'h7FC0, 16'hFF80, 16'h7FC0,
                               16'h0000, 16'h8000, 16'h7F80, 16'h3FC2, 16'h3FC4};

    initial begin
        logic [15:0] a, b, e;
        io_in = '1;
        rst   = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;

        for (int k = 0; k < 15; k++) send_group(dir_a[k], dir_b[k], dir_p[k]);

        // Framing error on the 2nd byte must drop the partial group.
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b0);
        send_group(16'h4040, 16'h4000, 16'h40C0);

        for (int k = 0; k < 12; k++) begin
            do begin
                a = rand_bf16();
                b = rand_bf16();
                e = ref_mul(a, b);
            end while (e == last_exp);
            send_group(a, b, e);
        end

        // Reset after two bytes and part of a third; nothing may be produced from them.
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        io_in[5] = 1'b0;
        repeat (C + 3) @(negedge clk);
        #1;
        rst      = 1'b1;
        io_in[5] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (GAP) @(negedge clk);
        #1;
        send_group(16'h3F80, 16'h4000, 16'h4000);

        repeat (GAP) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
